// File: rtl/return_addr_stack_if.sv
// Return-address stack port bundle.
// Fetch side drives call/return requests; the RAS answers with predictions.
interface return_addr_stack_if #(
  parameter int AW    = 32,
  parameter int PTR_W = 3
);
  logic             push;
  logic [AW-1:0]    push_addr;
  logic             pop;
  logic             flush;
  logic             pred_valid;
  logic [AW-1:0]    pred_addr;
  logic [AW-1:0]    top_addr;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, push_addr, pop, flush,
    input  pred_valid, pred_addr, top_addr,
    input  count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, push_addr, pop, flush,
    output pred_valid, pred_addr, top_addr,
    output count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack for the fetch path.
// Calls push the link address; returns pop a one-cycle-late target.
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int AW    = 32
) (
  input logic                clk,
  input logic                rst_n,
  return_addr_stack_if.slave ras
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [AW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] tos, tos_n;
  logic [PTR_W:0]   cnt, cnt_n;
  logic             pv, pv_n;
  logic [AW-1:0]    pa, pa_n;
  logic             ovf, ovf_n;
  logic             unf, unf_n;
  logic             we;
  logic [PTR_W-1:0] wptr;

  logic do_fl, do_pp, do_pu, do_po;
  logic has;

  assign has   = (cnt != '0);
  assign do_fl = ras.flush;
  assign do_pp = !ras.flush && ras.push && ras.pop;
  assign do_pu = !ras.flush && ras.push && !ras.pop;
  assign do_po = !ras.flush && !ras.push && ras.pop;

  // Next-state decode for pointer, count, prediction and sticky flags
  always_comb begin
    tos_n = tos;
    cnt_n = cnt;
    pv_n  = 1'b0;
    pa_n  = pa;
    ovf_n = ovf;
    unf_n = unf;
    we    = 1'b0;
    wptr  = tos + 1'b1;
    unique case (1'b1)
      do_fl: begin
        tos_n = '0;
        cnt_n = '0;
        ovf_n = 1'b0;
        unf_n = 1'b0;
      end
      do_pp: begin
        if (has) begin
          pa_n = mem[tos];
          pv_n = 1'b1;
          we   = 1'b1;
          wptr = tos;
        end else begin
          unf_n = 1'b1;
          we    = 1'b1;
          tos_n = tos + 1'b1;
          cnt_n = {{PTR_W{1'b0}}, 1'b1};
        end
      end
      do_pu: begin
        we    = 1'b1;
        tos_n = tos + 1'b1;
        if (cnt == FULL_CNT) ovf_n = 1'b1;
        else cnt_n = cnt + 1'b1;
      end
      do_po: begin
        if (has) begin
          pa_n  = mem[tos];
          pv_n  = 1'b1;
          tos_n = tos - 1'b1;
          cnt_n = cnt - 1'b1;
        end else begin
          unf_n = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control state, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos <= '0;
      cnt <= '0;
      pv  <= 1'b0;
      pa  <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      tos <= tos_n;
      cnt <= cnt_n;
      pv  <= pv_n;
      pa  <= pa_n;
      ovf <= ovf_n;
      unf <= unf_n;
    end
  end

  // Storage array; contents are only visible through count, so no reset
  always_ff @(posedge clk) begin
    if (we && rst_n) mem[wptr] <= ras.push_addr;
  end

  assign ras.pred_valid = pv;
  assign ras.pred_addr  = pa;
  assign ras.top_addr   = has ? mem[tos] : '0;
  assign ras.count      = cnt;
  assign ras.empty      = !has;
  assign ras.full       = (cnt == FULL_CNT);
  assign ras.overflow   = ovf;
  assign ras.underflow  = unf;

endmodule
